// File: rtl/instruction_memory_loader_pkg.sv
// -----------------------------------------------------------------------------
// instruction_memory_loader_pkg
// Shared types and constants for the boot-time instruction memory loader:
//   state_t        - loader FSM states
//   HDR_LEN        - number of header bytes (little-endian word count)
//   CNT_WIDTH      - width of the header word count
//   checksum_fold  - running XOR checksum step over the data bytes
//   in_load        - true for states in which a load is in progress
// -----------------------------------------------------------------------------
package instruction_memory_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam int HDR_LEN   = 2;
    localparam int CNT_WIDTH = 16;

    // One step of the image checksum: XOR of all data bytes.
    function automatic logic [7:0] checksum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // States in which the loader accepts stream bytes and reports Busy.
    function automatic logic in_load(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/instruction_memory_loader.sv
// -----------------------------------------------------------------------------
// instruction_memory_loader
// Boot-time writer for the byte-array instruction memory. Parses a frame from
// a valid/ready byte stream: word count N (2 bytes, LE), 4*N image bytes, one
// XOR checksum byte. Image bytes are written little-endian from byte address 0
// one cycle after acceptance. The core is held in reset (CpuHold) until an
// image with a matching checksum has been written.
// Ports:
//   Clk, RstN           clock, asynchronous active-low reset
//   Start               pulse to begin a load (ignored while a load runs)
//   RxData/RxValid      incoming stream byte; RxReady = loader can accept
//   WrEn/WrAddr/WrData  registered memory byte write port
//   CpuHold             1 = keep processor in reset
//   Busy                load in progress
//   Done                last load passed its checksum
//   ErrOverflow         header word count larger than memory capacity
//   ErrChecksum         trailing checksum did not match the image
// -----------------------------------------------------------------------------
module instruction_memory_loader
    import instruction_memory_loader_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic                  Clk,
    input  logic                  RstN,
    input  logic                  Start,
    input  logic [7:0]            RxData,
    input  logic                  RxValid,
    output logic                  RxReady,
    output logic                  WrEn,
    output logic [ADDR_WIDTH+1:0] WrAddr,
    output logic [7:0]            WrData,
    output logic                  CpuHold,
    output logic                  Busy,
    output logic                  Done,
    output logic                  ErrOverflow,
    output logic                  ErrChecksum
);

    localparam int                   BCNT_W    = CNT_WIDTH + 2;
    localparam logic [31:0]          CAP_WORDS = 32'd1 << ADDR_WIDTH;
    localparam logic [BCNT_W-1:0]    BCNT_ONE  = BCNT_W'(1);

    state_t                   state_r;
    state_t                   state_s;

    logic                     load_r;       // drives both RxReady and Busy
    logic [7:0]               len_lo_r;
    logic [BCNT_W-1:0]        total_r;      // image length in bytes (4*N)
    logic [BCNT_W-1:0]        cnt_r;        // data bytes accepted so far
    logic [7:0]               xor_r;
    logic                     wr_en_r;
    logic [ADDR_WIDTH+1:0]    wr_addr_r;
    logic [7:0]               wr_data_r;
    logic                     cpu_hold_r;
    logic                     done_r;
    logic                     err_ovf_r;
    logic                     err_chk_r;

    logic                     acc_s;
    logic                     start_s;
    logic [HDR_LEN*8-1:0]     n_s;
    logic                     ovf_s;
    logic                     last_s;
    logic                     sum_ok_s;

    // Handshake, header decode and end-of-image detection.
    always_comb begin
        acc_s    = RxValid && load_r;
        start_s  = Start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));
        n_s      = {RxData, len_lo_r};
        ovf_s    = (32'(n_s) > CAP_WORDS);
        last_s   = (cnt_r == (total_r - BCNT_ONE));
        sum_ok_s = (RxData == xor_r);
    end

    // Next-state logic of the frame parser.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE, ERR: begin
                if (start_s) begin
                    state_s = LEN_LO;
                end else begin
                    state_s = state_r;
                end
            end
            LEN_LO: begin
                if (acc_s) begin
                    state_s = LEN_HI;
                end else begin
                    state_s = state_r;
                end
            end
            LEN_HI: begin
                if (!acc_s) begin
                    state_s = state_r;
                end else if (ovf_s) begin
                    state_s = ERR;
                end else if (n_s == '0) begin
                    state_s = CHECK;    // empty image: checksum byte follows directly
                end else begin
                    state_s = DATA;
                end
            end
            DATA: begin
                if (acc_s && last_s) begin
                    state_s = CHECK;
                end else begin
                    state_s = state_r;
                end
            end
            CHECK: begin
                if (!acc_s) begin
                    state_s = state_r;
                end else if (sum_ok_s) begin
                    state_s = DONE;
                end else begin
                    state_s = ERR;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: counters, checksum, registered write port and status flags.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            load_r     <= 1'b0;
            len_lo_r   <= 8'd0;
            total_r    <= '0;
            cnt_r      <= '0;
            xor_r      <= 8'd0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= '0;
            wr_data_r  <= 8'd0;
            cpu_hold_r <= HOLD_AT_RESET;
            done_r     <= 1'b0;
            err_ovf_r  <= 1'b0;
            err_chk_r  <= 1'b0;
        end else begin
            load_r  <= in_load(state_s);
            wr_en_r <= 1'b0;

            if (start_s) begin
                cnt_r      <= '0;
                xor_r      <= 8'd0;
                cpu_hold_r <= 1'b1;
                done_r     <= 1'b0;
                err_ovf_r  <= 1'b0;
                err_chk_r  <= 1'b0;
            end

            if (acc_s) begin
                case (state_r)
                    LEN_LO: begin
                        len_lo_r <= RxData;
                    end
                    LEN_HI: begin
                        total_r <= {n_s, 2'b00};
                        if (ovf_s) begin
                            err_ovf_r <= 1'b1;
                        end
                    end
                    DATA: begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= cnt_r[ADDR_WIDTH+1:0];
                        wr_data_r <= RxData;
                        cnt_r     <= cnt_r + BCNT_ONE;
                        xor_r     <= checksum_fold(xor_r, RxData);
                    end
                    CHECK: begin
                        if (sum_ok_s) begin
                            done_r     <= 1'b1;
                            cpu_hold_r <= 1'b0;
                        end else begin
                            err_chk_r  <= 1'b1;
                        end
                    end
                    default: begin
                        len_lo_r <= len_lo_r;
                    end
                endcase
            end
        end
    end

    assign RxReady     = load_r;
    assign Busy        = load_r;
    assign WrEn        = wr_en_r;
    assign WrAddr      = wr_addr_r;
    assign WrData      = wr_data_r;
    assign CpuHold     = cpu_hold_r;
    assign Done        = done_r;
    assign ErrOverflow = err_ovf_r;
    assign ErrChecksum = err_chk_r;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_memory_loader
// Self-checking bench: a frame-level model (byte index within the frame decides
// the role of each accepted byte) predicts every output each cycle; literal
// expectations pin the model on the fixed example frames.
// -----------------------------------------------------------------------------
module tb_instruction_memory_loader;

    localparam int AW = 10;

    logic          Clk = 1'b0;
    logic          RstN = 1'b0;
    logic          Start = 1'b0;
    logic [7:0]    RxData = 8'd0;
    logic          RxValid = 1'b0;
    logic          RxReady;
    logic          WrEn;
    logic [AW+1:0] WrAddr;
    logic [7:0]    WrData;
    logic          CpuHold;
    logic          Busy;
    logic          Done;
    logic          ErrOverflow;
    logic          ErrChecksum;

    instruction_memory_loader #(.ADDR_WIDTH(AW), .HOLD_AT_RESET(1'b1)) dut (
        .Clk(Clk), .RstN(RstN), .Start(Start), .RxData(RxData), .RxValid(RxValid),
        .RxReady(RxReady), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .CpuHold(CpuHold), .Busy(Busy), .Done(Done),
        .ErrOverflow(ErrOverflow), .ErrChecksum(ErrChecksum)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_active = 1'b0;
    int         m_idx    = 0;
    int         m_n      = 0;
    logic [7:0] m_lo     = 8'd0;
    logic [7:0] m_xor    = 8'd0;
    bit         m_done   = 1'b0;
    bit         m_ovf    = 1'b0;
    bit         m_chk    = 1'b0;
    bit         m_hold   = 1'b1;
    bit         m_wr_en  = 1'b0;
    int         m_wr_addr = 0;
    logic [7:0] m_wr_data = 8'd0;

    always @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            m_active = 1'b0; m_idx = 0; m_n = 0; m_xor = 8'd0;
            m_done = 1'b0; m_ovf = 1'b0; m_chk = 1'b0; m_hold = 1'b1; m_wr_en = 1'b0;
        end else begin
            m_wr_en = 1'b0;
            if (Start && !m_active) begin
                m_active = 1'b1; m_idx = 0; m_xor = 8'd0;
                m_done = 1'b0; m_ovf = 1'b0; m_chk = 1'b0; m_hold = 1'b1;
            end else if (m_active && RxValid) begin
                if (m_idx == 0) begin
                    m_lo = RxData;
                end else if (m_idx == 1) begin
                    m_n = int'({RxData, m_lo});
                    if (m_n > (1 << AW)) begin
                        m_ovf = 1'b1; m_active = 1'b0;
                    end
                end else if (m_idx < 2 + 4 * m_n) begin
                    m_wr_en = 1'b1; m_wr_addr = m_idx - 2; m_wr_data = RxData;
                    m_xor = m_xor ^ RxData;
                end else begin
                    m_active = 1'b0;
                    if (RxData == m_xor) begin
                        m_done = 1'b1; m_hold = 1'b0;
                    end else begin
                        m_chk = 1'b1;
                    end
                end
                m_idx++;
            end
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    logic [19:0] wlog [$];

    always @(negedge Clk) begin
        if (chk_en) begin
            check("RxReady", 32'(RxReady), 32'(m_active));
            check("Busy", 32'(Busy), 32'(m_active));
            check("WrEn", 32'(WrEn), 32'(m_wr_en));
            if (m_wr_en) begin
                check("WrAddr", 32'(WrAddr), 32'(m_wr_addr));
                check("WrData", 32'(WrData), 32'(m_wr_data));
            end
            check("Done", 32'(Done), 32'(m_done));
            check("ErrOverflow", 32'(ErrOverflow), 32'(m_ovf));
            check("ErrChecksum", 32'(ErrChecksum), 32'(m_chk));
            check("CpuHold", 32'(CpuHold), 32'(m_hold));
        end
        if (WrEn === 1'b1) wlog.push_back({WrAddr, WrData});
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] frame_q [$];

    task automatic start_pulse();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic send_queue(input int gap_max, input bit noise);
        bit r;
        foreach (frame_q[i]) begin
            repeat ($urandom_range(gap_max, 0)) begin
                RxValid = 1'b0;
                Start = (noise && ($urandom % 3 == 0));
                @(posedge Clk); #1;
                Start = 1'b0;
            end
            RxValid = 1'b1;
            RxData  = frame_q[i];
            r = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge Clk);
                r = RxReady;
                @(posedge Clk); #1;
                if (r) break;
            end
            if (!r) check("accept_timeout", 32'd0, 32'd1);
        end
        RxValid = 1'b0;
    endtask

    task automatic build_frame(input int n, input bit good);
        logic [7:0] x;
        logic [7:0] b;
        logic [15:0] nn;
        nn = 16'(n);
        x = 8'd0;
        frame_q.delete();
        frame_q.push_back(nn[7:0]);
        frame_q.push_back(nn[15:8]);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            frame_q.push_back(b);
        end
        frame_q.push_back(good ? x : (x ^ 8'h5A));
    endtask

    task automatic settle();
        repeat (2) @(posedge Clk);
        #1;
        @(negedge Clk);
    endtask

    task automatic load_example(input logic [7:0] sum);
        frame_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                    8'h13, 8'h01, 8'hA0, 8'h00, sum};
    endtask

    task automatic check_example_log(input string tag);
        logic [7:0] exp_d [8];
        exp_d = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
        check({tag, "_nwrites"}, 32'(wlog.size()), 32'd8);
        if (wlog.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check({tag, "_addr"}, 32'(wlog[i][19:8]), 32'(i));
                check({tag, "_data"}, 32'(wlog[i][7:0]), 32'(exp_d[i]));
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        bit good;
        repeat (2) @(posedge Clk);
        chk_en = 1'b1;
        @(negedge Clk);
        // reset state
        check("rst_CpuHold", 32'(CpuHold), 32'd1);
        check("rst_RxReady", 32'(RxReady), 32'd0);
        check("rst_WrEn", 32'(WrEn), 32'd0);
        check("rst_WrAddr", 32'(WrAddr), 32'd0);
        check("rst_Busy", 32'(Busy), 32'd0);
        check("rst_Done", 32'(Done), 32'd0);
        check("rst_Err", 32'({ErrOverflow, ErrChecksum}), 32'd0);
        @(posedge Clk); #1;
        RstN = 1'b1;
        @(posedge Clk); #1;

        // good load
        wlog.delete();
        start_pulse();
        load_example(8'h71);
        send_queue(0, 1'b0);
        settle();
        check_example_log("good");
        check("good_Done", 32'(Done), 32'd1);
        check("good_CpuHold", 32'(CpuHold), 32'd0);
        check("good_Busy", 32'(Busy), 32'd0);
        @(posedge Clk); #1;

        // bad checksum
        wlog.delete();
        start_pulse();
        load_example(8'h70);
        send_queue(0, 1'b0);
        settle();
        check("bad_ErrChecksum", 32'(ErrChecksum), 32'd1);
        check("bad_Done", 32'(Done), 32'd0);
        check("bad_CpuHold", 32'(CpuHold), 32'd1);
        check("bad_nwrites", 32'(wlog.size()), 32'd8);
        @(posedge Clk); #1;

        // overflow
        wlog.delete();
        start_pulse();
        frame_q = '{8'h01, 8'h04};
        send_queue(0, 1'b0);
        @(negedge Clk);
        check("ovf_ErrOverflow", 32'(ErrOverflow), 32'd1);
        check("ovf_RxReady", 32'(RxReady), 32'd0);
        settle();
        check("ovf_nwrites", 32'(wlog.size()), 32'd0);
        @(posedge Clk); #1;

        // backpressure and ignored Start pulses
        wlog.delete();
        start_pulse();
        load_example(8'h71);
        send_queue(4, 1'b1);
        settle();
        check_example_log("bp");
        check("bp_Done", 32'(Done), 32'd1);
        @(posedge Clk); #1;

        // random frames
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(6, 0);
            good = ($urandom % 2 == 0);
            start_pulse();
            build_frame(n, good);
            send_queue($urandom_range(3, 0), 1'b1);
            settle();
            @(posedge Clk); #1;
        end

        // capacity boundary: exactly full memory, then one word too many
        wlog.delete();
        start_pulse();
        build_frame(1 << AW, 1'b1);
        send_queue(0, 1'b0);
        settle();
        check("full_nwrites", 32'(wlog.size()), 32'd4096);
        if (wlog.size() > 0) check("full_lastaddr", 32'(wlog[$][19:8]), 32'hFFF);
        check("full_Done", 32'(Done), 32'd1);
        @(posedge Clk); #1;
        start_pulse();
        frame_q = '{8'h01, 8'h04};
        frame_q[0] = 8'h01;
        frame_q[1] = 8'h04;
        send_queue(2, 1'b0);
        settle();
        check("cap1025_ErrOverflow", 32'(ErrOverflow), 32'd1);
        @(posedge Clk); #1;

        // reset in the middle of image data
        wlog.delete();
        start_pulse();
        frame_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        send_queue(0, 1'b0);
        RstN = 1'b0;
        @(negedge Clk);
        check("mid_rst_CpuHold", 32'(CpuHold), 32'd1);
        check("mid_rst_RxReady", 32'(RxReady), 32'd0);
        check("mid_rst_WrEn", 32'(WrEn), 32'd0);
        check("mid_rst_Busy", 32'(Busy), 32'd0);
        @(posedge Clk); #1;
        RstN = 1'b1;
        @(posedge Clk); #1;
        wlog.delete();
        start_pulse();
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_queue(1, 1'b0);
        settle();
        check("empty_Done", 32'(Done), 32'd1);
        check("empty_nwrites", 32'(wlog.size()), 32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
